// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage access sequencer.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic SIZE_BYTE  = 1'b0;
    localparam logic SIZE_WORD  = 1'b1;
    localparam logic RW_LOAD    = 1'b0;
    localparam logic RW_STORE   = 1'b1;
    localparam int   WORD_BEATS = 4;

endpackage

// File: rtl/mem_byte_lane.sv
// Store-data byte selector: picks the byte a given beat writes.
// Word stores are big-endian (beat 0 = MSB); byte stores always use bits [7:0].
module mem_byte_lane
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              size_i,
    input  logic [1:0]        beat_i,
    output logic [7:0]        byte_o
);

    // Beat-to-byte mux; byte size ignores the beat index.
    always_comb begin
        byte_o = wdata_i[7:0];
        if (size_i == SIZE_WORD) begin
            case (beat_i)
                2'd0:    byte_o = wdata_i[31:24];
                2'd1:    byte_o = wdata_i[23:16];
                2'd2:    byte_o = wdata_i[15:8];
                default: byte_o = wdata_i[7:0];
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer to a byte-wide data RAM. Byte accesses take one beat,
// word accesses four big-endian beats on the aligned address. stall holds the
// pipeline while in flight; done pulses for one cycle with rdata/misalign.
// Optional: define MEM_ACCESS_PERF_CNT_EN to add a saturating stall-cycle counter.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              R,
    input  logic              req_valid,
    input  logic              req_rw,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              stall,
`ifdef MEM_ACCESS_PERF_CNT_EN
    output logic [15:0]       perf_stall_cnt,
`endif
    output logic              misalign
);

    state_e            state_q;
    logic [1:0]        beat_q;
    logic              rw_q;
    logic              size_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic              mis_q;
    logic              last_beat;
    logic [7:0]        lane_byte;

    assign last_beat = (size_q == SIZE_BYTE) || (beat_q == 2'(WORD_BEATS - 1));

    mem_byte_lane #(.DATA_W(DATA_W)) u_lane (
        .wdata_i (wdata_q),
        .size_i  (size_q),
        .beat_i  (beat_q),
        .byte_o  (lane_byte)
    );

    // RAM strobes and stall are decoded from state; address/data forced to 0 when idle.
    always_comb begin
        ram_en    = (state_q == ACCESS);
        ram_we    = ram_en & (rw_q == RW_STORE);
        ram_addr  = ram_en ? (base_q + ADDR_W'(beat_q)) : '0;
        ram_wdata = ram_en ? lane_byte : 8'h00;
        stall     = (state_q == ACCESS) || ((state_q == IDLE) && req_valid);
    end

    // Sequencer FSM: accept in IDLE, step beats in ACCESS, pulse done in DONE.
    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            rw_q    <= RW_LOAD;
            size_q  <= SIZE_BYTE;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rw_q    <= req_rw;
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                        beat_q  <= 2'd0;
                        mis_q   <= (req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00);
                        base_q  <= (req_size == SIZE_WORD) ? {req_addr[ADDR_W-1:2], 2'b00}
                                                           : req_addr;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Word loads shift bytes in MSB-first; byte loads zero-extend.
                    if (rw_q == RW_LOAD) begin
                        if (size_q == SIZE_WORD)
                            rdata_q <= {rdata_q[DATA_W-9:0], ram_rdata};
                        else
                            rdata_q <= {{(DATA_W-8){1'b0}}, ram_rdata};
                    end
                    if (last_beat) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        beat_q <= beat_q + 2'd1;
                    end
                end
                default: begin
                    // DONE (and any stray encoding) returns to IDLE; req_valid ignored here.
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata    = rdata_q;
    assign done     = done_q;
    assign misalign = mis_q;

`ifdef MEM_ACCESS_PERF_CNT_EN
    logic [15:0] perf_q;

    // Count stalled cycles, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (R)
            perf_q <= 16'h0000;
        else if (stall && (perf_q != 16'hFFFF))
            perf_q <= perf_q + 16'h0001;
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 256x8 RAM.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rw = 1'b0;
    logic        req_size = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic [7:0]  ram_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr, ram_wdata;
    logic [31:0] rdata;
    logic        done, stall, misalign;
`ifdef MEM_ACCESS_PERF_CNT_EN
    logic [15:0] perf_stall_cnt;
`endif

    logic [7:0]  mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = 8'h00;
    logic [7:0]  pre_data = 8'h00;

    int          n_tests = 0;
    int          n_fail = 0;

    int          done_at, stall_n, nbeat;
    logic [7:0]  addr_seq [4];
    logic [31:0] obs_rdata;
    logic        obs_mis;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk       (clk),
        .R         (R),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ram_rdata (ram_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .rdata     (rdata),
        .done      (done),
        .stall     (stall),
`ifdef MEM_ACCESS_PERF_CNT_EN
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .misalign  (misalign)
    );

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        else if (pre_we)      mem[pre_addr] <= pre_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        R = 1'b1;
        @(posedge clk); #1;
        R = 1'b0;
    endtask

    // Issue one request; cycle 0 is the IDLE cycle in which it is sampled.
    task automatic issue(input logic rw, input logic size, input logic [7:0] a,
                         input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_rw = rw; req_size = size; req_addr = a; req_wdata = wd;
        done_at = -1; stall_n = 0; nbeat = 0;
        obs_rdata = 32'hx; obs_mis = 1'bx;
        for (int i = 0; i < 4; i++) addr_seq[i] = 8'hxx;
        for (int c = 0; c < 20 && done_at < 0; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (ram_en && nbeat < 4) begin addr_seq[nbeat] = ram_addr; nbeat++; end
            if (done) begin done_at = c; obs_rdata = rdata; obs_mis = misalign; end
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        if (done_at < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int d1, d2, sc;
        logic s5, s6;

        // Reset state
        @(posedge clk); @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_ram", {22'd0, ram_en, ram_we, ram_addr}, 32'd0);
        chk("rst_wdata", {24'd0, ram_wdata}, 32'd0);
        @(posedge clk); #1; R = 1'b0;

        // Word store 0xDEADBEEF to 0x10
        issue(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        chk("wst_done_at", done_at, 5);
        chk("wst_stall_n", stall_n, 5);
        chk("wst_mis", {31'd0, obs_mis}, 32'd0);
        chk("wst_addrs", {addr_seq[0], addr_seq[1], addr_seq[2], addr_seq[3]}, 32'h10111213);
        chk("wst_mem", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEADBEEF);

        // Word load from 0x20
        poke(8'h20, 8'h01); poke(8'h21, 8'h23); poke(8'h22, 8'h45); poke(8'h23, 8'h67);
        issue(1'b0, 1'b1, 8'h20, 32'h0);
        chk("wld_done_at", done_at, 5);
        chk("wld_rdata", obs_rdata, 32'h01234567);
        chk("wld_mis", {31'd0, obs_mis}, 32'd0);

        // Byte store to 0x07, neighbours untouched, rdata unchanged
        poke(8'h06, 8'hA6); poke(8'h07, 8'h00); poke(8'h08, 8'hA8);
        issue(1'b1, 1'b0, 8'h07, 32'h11223355);
        chk("bst_done_at", done_at, 2);
        chk("bst_stall_n", stall_n, 2);
        chk("bst_mem", {8'd0, mem[8'h06], mem[8'h07], mem[8'h08]}, 32'h00A655A8);
        chk("bst_rdata_hold", obs_rdata, 32'h01234567);

        // Byte load from 0xFF
        poke(8'hFF, 8'h9A);
        issue(1'b0, 1'b0, 8'hFF, 32'h0);
        chk("bld_done_at", done_at, 2);
        chk("bld_stall_n", stall_n, 2);
        chk("bld_addr", {24'd0, addr_seq[0]}, 32'h000000FF);
        chk("bld_rdata", obs_rdata, 32'h0000009A);

        // Misaligned word load from 0x22
        issue(1'b0, 1'b1, 8'h22, 32'h0);
        chk("mis_done_at", done_at, 5);
        chk("mis_flag", {31'd0, obs_mis}, 32'd1);
        chk("mis_addrs", {addr_seq[0], addr_seq[1], addr_seq[2], addr_seq[3]}, 32'h20212223);
        chk("mis_rdata", obs_rdata, 32'h01234567);

        // Reset lands at the edge that would start beat 2 of a word store
        poke(8'h30, 8'h00); poke(8'h31, 8'h00); poke(8'h32, 8'h00); poke(8'h33, 8'h00);
        @(posedge clk); #1;
        req_valid = 1'b1; req_rw = 1'b1; req_size = 1'b1; req_addr = 8'h30;
        req_wdata = 32'hAABBCCDD;
        begin
            bit hit = 1'b0;
            for (int c = 0; c < 10 && !hit; c++) begin
                @(negedge clk);
                if (ram_en && ram_addr == 8'h31) begin R = 1'b1; hit = 1'b1; end
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
            chk("mrst_reached_beat1", {31'd0, hit}, 32'd1);
        end
        R = 1'b0;
        @(negedge clk);
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        chk("mrst_ram_en", {31'd0, ram_en}, 32'd0);
        d1 = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) d1++;
            @(negedge clk);
        end
        chk("mrst_no_done", d1, 0);
        chk("mrst_mem", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 32'hAABB0000);

        // Back-to-back word loads with req_valid held across DONE
        do_reset();
        req_valid = 1'b1; req_rw = 1'b0; req_size = 1'b1; req_addr = 8'h20;
        d1 = -1; d2 = -1; sc = 0; s5 = 1'bx; s6 = 1'bx;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (stall) sc++;
            if (c == 5) s5 = stall;
            if (c == 6) s6 = stall;
            if (done) begin
                if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
            end
            @(posedge clk); #1;
            if (c == 11) req_valid = 1'b0;
        end
        chk("b2b_done1", d1, 5);
        chk("b2b_done2", d2, 11);
        chk("b2b_stall_in_done", {31'd0, s5}, 32'd0);
        chk("b2b_stall_reaccept", {31'd0, s6}, 32'd1);
        chk("b2b_stall_total", sc, 10);
        chk("b2b_rdata", rdata, 32'h01234567);
`ifdef MEM_ACCESS_PERF_CNT_EN
        @(negedge clk);
        chk("perf_cnt", {16'd0, perf_stall_cnt}, 32'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
